// File: rtl/number_display_seq.sv
// Sequential binary-to-decimal seven-segment driver.
// Converts a WIDTH-bit unsigned value to NUM_DIGITS BCD digits by
// shift-and-add-3 (double-dabble), one bit per clock. The bcd, segs and
// overflow outputs change together in one cycle when a conversion ends.
module number_display_seq #(
    parameter int WIDTH          = 16,
    parameter int NUM_DIGITS     = 4,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        value,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [7*NUM_DIGITS-1:0] segs
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_UPDATE
    } state_t;

    // Active-high gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // Full display image: dashes on overflow, optional leading-zero
    // blanking scanned from the top digit down, then output polarity.
    function automatic logic [SW-1:0] encode(input logic [BW-1:0] digits,
                                             input logic           ovf);
        logic [SW-1:0] s;
        logic [6:0]    p;
        logic          lit;
        s   = '0;
        lit = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (digits[4*k +: 4] != 4'd0) lit = 1'b1;
            if (ovf)
                p = 7'b1000000;
            else if (BLANK_LZ != 0 && k != 0 && !lit)
                p = 7'b0000000;
            else
                p = seg_digit(digits[4*k +: 4]);
            s[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~p : p;
        end
        return s;
    endfunction

    state_t          r_state;
    logic [WIDTH-1:0] r_bin;
    logic [BW-1:0]   r_work;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic            r_busy;
    logic            r_done;
    logic            r_overflow;
    logic [BW-1:0]   r_bcd;
    logic [SW-1:0]   r_segs;

    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_work_nxt;
    logic [WIDTH-1:0] w_bin_nxt;
    logic             w_carry;
    logic [SW-1:0]    w_segs_nxt;

    // One double-dabble step: add 3 to digits >= 5, then shift left by one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_adj = r_work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
        w_carry    = w_adj[BW-1];
        w_work_nxt = {w_adj[BW-2:0], r_bin[WIDTH-1]};
        w_bin_nxt  = {r_bin[WIDTH-2:0], 1'b0};
        w_segs_nxt = encode(w_work_nxt, r_ovf | w_carry);
    end

    // Control FSM with registered outputs; results load on the final shift
    // so they appear together with done in the UPDATE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            // NOTE: the working datapath is reset too; it is a handful of
            // flops, not a memory array, so the cost is negligible.
            r_bin      <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_bcd      <= '0;
            r_segs     <= encode('0, 1'b0);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= value;
                        r_work  <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bin  <= w_bin_nxt;
                    r_work <= w_work_nxt;
                    r_ovf  <= r_ovf | w_carry;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_bcd      <= w_work_nxt;
                        r_overflow <= r_ovf | w_carry;
                        r_segs     <= w_segs_nxt;
                        r_done     <= 1'b1;
                        r_state    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign bcd      = r_bcd;
    assign segs     = r_segs;

endmodule

// File: tb/tb_number_display_seq.sv
// Directed self-checking bench for number_display_seq. Three instances
// share clock, reset and stimulus: default (4 digits, active-low),
// 5 digits, and active-high segments.
module tb_number_display_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        start;

    logic        busy, done, overflow;
    logic [15:0] bcd;
    logic [27:0] segs;

    logic        busy5, done5, overflow5;
    logic [19:0] bcd5;
    logic [34:0] segs5;

    logic        busy_h, done_h, overflow_h;
    logic [15:0] bcd_h;
    logic [27:0] segs_h;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int busy_low;
    int n_done;
    int done_cyc;

    // Active-high gfedcba patterns, written out by hand.
    localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F,
                           P4 = 7'h66, P5 = 7'h6D, P6 = 7'h7D, P7 = 7'h07,
                           P8 = 7'h7F, P9 = 7'h6F, PD = 7'h40, PB = 7'h00;

    number_display_seq #(.WIDTH(16), .NUM_DIGITS(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .start(start),
        .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .segs(segs)
    );

    number_display_seq #(.WIDTH(16), .NUM_DIGITS(5), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .value(value), .start(start),
        .busy(busy5), .done(done5), .overflow(overflow5), .bcd(bcd5), .segs(segs5)
    );

    number_display_seq #(.WIDTH(16), .NUM_DIGITS(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .value(value), .start(start),
        .busy(busy_h), .done(done_h), .overflow(overflow_h), .bcd(bcd_h), .segs(segs_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse start, then count cycles (from 1 = cycle after acceptance) until
    // done rises; records cycles where busy was low. Bounded at 40 cycles.
    task automatic convert(input logic [15:0] v, output int l, output int bl);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l  = 1;
        bl = 0;
        while (!done && l < 40) begin
            if (!busy) bl++;
            @(negedge clk);
            l++;
        end
        if (!busy) bl++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        #23;
        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_bcd", bcd, 0);
        check("rst_segs", segs, {~PB, ~PB, ~PB, ~P0});
        check("rst_segs_h", segs_h, {PB, PB, PB, P0});
        @(negedge clk);
        rst_n = 1'b1;

        // 1234: latency, busy window, result
        convert(16'd1234, lat, busy_low);
        check("lat_1234", lat, 17);
        check("busy_win", busy_low, 0);
        check("done_1234", done, 1);
        check("bcd_1234", bcd, 16'h1234);
        check("ovf_1234", overflow, 0);
        check("segs_1234", segs, {~P1, ~P2, ~P3, ~P4});
        @(negedge clk);
        check("busy_after", busy, 0);
        check("done_after", done, 0);

        // 7 and 0: leading-zero blanking
        convert(16'd7, lat, busy_low);
        check("bcd_7", bcd, 16'h0007);
        check("segs_7", segs, {~PB, ~PB, ~PB, ~P7});
        check("segs_h_7", segs_h, {PB, PB, PB, P7});
        convert(16'd0, lat, busy_low);
        check("bcd_0", bcd, 16'h0000);
        check("segs_0", segs, {~PB, ~PB, ~PB, ~P0});

        // 9999 / 10000 / 65535: overflow boundary
        convert(16'd9999, lat, busy_low);
        check("ovf_9999", overflow, 0);
        check("segs_9999", segs, {~P9, ~P9, ~P9, ~P9});
        convert(16'd10000, lat, busy_low);
        check("ovf_10000", overflow, 1);
        check("bcd_10000", bcd, 16'h0000);
        check("segs_10000", segs, {~PD, ~PD, ~PD, ~PD});
        check("bcd5_10000", bcd5, 20'h10000);
        check("segs5_10000", segs5, {~P1, ~P0, ~P0, ~P0, ~P0});
        convert(16'd65535, lat, busy_low);
        check("ovf5_65535", overflow5, 0);
        check("bcd5_65535", bcd5, 20'h65535);
        check("ovf_65535", overflow, 1);
        check("bcd_65535", bcd, 16'h5535);

        // 42, then a start for 99 at cycle 5 while busy (ignored)
        @(negedge clk);
        value = 16'd42;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        done_cyc = 0;
        for (int c = 1; c <= 25; c++) begin
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (c == 10) begin
                check("hold_segs", segs, {~PD, ~PD, ~PD, ~PD});
                check("hold_ovf", overflow, 1);
            end
            if (c == 5) begin
                value = 16'd99;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("ign_ndone", n_done, 1);
        check("ign_cyc", done_cyc, 17);
        check("ign_bcd", bcd, 16'h0042);
        check("ign_segs", segs, {~PB, ~PB, ~P4, ~P2});

        // Reset at cycle 8 of a 5678 conversion
        @(negedge clk);
        value = 16'd5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_bcd", bcd, 0);
        check("mid_segs", segs, {~PB, ~PB, ~PB, ~P0});
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("mid_nodone", n_done, 0);
        convert(16'd5678, lat, busy_low);
        check("lat_5678", lat, 17);
        check("bcd_5678", bcd, 16'h5678);
        check("segs_5678", segs, {~P5, ~P6, ~P7, ~P8});

        // Polarity with value 8
        convert(16'd8, lat, busy_low);
        check("segs_8_low", segs, {7'h7F, 7'h7F, 7'h7F, 7'h00});
        check("segs_8_high", segs_h, {7'h00, 7'h00, 7'h00, 7'h7F});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
